// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - load-use stall, branch flush and dcache-miss freeze sequencing
module hazard_stall_ctrl #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       ID_rs_1,
  input  logic [4:0]       ID_rs_2,
  input  logic             EX_MemRead,
  input  logic [4:0]       EX_rd,
  input  logic             ID_branch_taken,
  input  logic             MEM_mem_req,
  input  logic             dcache_stall_i,
  input  logic             dcache_ack_i,
  output logic             PC_write,
  output logic             IFID_write,
  output logic             IFID_flush,
  output logic             IDEX_bubble,
  output logic             pipe_freeze,
  output logic             timeout_o,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = (TIMEOUT == 0) ? '0 : WAIT_W'(TIMEOUT - 1);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t            r_state, w_next_state;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_miss_cnt;
  logic              r_timeout;

  logic w_miss_start;
  logic w_freeze;
  logic w_load_use;
  logic w_timeout_hit;

  assign w_miss_start  = (r_state == RUN) & MEM_mem_req & dcache_stall_i;
  assign w_freeze      = w_miss_start | ((r_state == MEM_WAIT) & ~dcache_ack_i);
  // A frozen pipeline is not advancing, so a load-use bubble would be meaningless.
  assign w_load_use    = EX_MemRead & (EX_rd != 5'd0) &
                         ((EX_rd == ID_rs_1) | (EX_rd == ID_rs_2)) & ~w_freeze;
  assign w_timeout_hit = (TIMEOUT != 0) && (r_wait_cnt == WAIT_LAST);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      RUN:      if (w_miss_start) w_next_state = MEM_WAIT;
      MEM_WAIT: if (dcache_ack_i) w_next_state = RUN;
      default:  w_next_state = RUN;
    endcase
  end

  always_comb begin
    PC_write    = 1'b1;
    IFID_write  = 1'b1;
    IFID_flush  = 1'b0;
    IDEX_bubble = 1'b0;
    pipe_freeze = 1'b0;
    if (rst_i) begin
      PC_write    = 1'b0;
      IFID_write  = 1'b0;
      IFID_flush  = 1'b1;
      IDEX_bubble = 1'b1;
    end else if (w_freeze) begin
      PC_write    = 1'b0;
      IFID_write  = 1'b0;
      pipe_freeze = 1'b1;
    end else if (w_load_use) begin
      // Branch flush is withheld: the branch re-resolves once the load data forwards.
      PC_write    = 1'b0;
      IFID_write  = 1'b0;
      IDEX_bubble = 1'b1;
    end else if (ID_branch_taken) begin
      IFID_flush  = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= RUN;
      r_wait_cnt  <= '0;
      r_stall_cnt <= '0;
      r_miss_cnt  <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_miss_start) begin
        r_wait_cnt <= '0;
        if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + CNT_W'(1);
      end else if ((r_state == MEM_WAIT) && !dcache_ack_i) begin
        if (w_timeout_hit) r_timeout <= 1'b1;
        if (r_wait_cnt != '1) r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
      end
      if ((w_freeze || w_load_use) && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign timeout_o = r_timeout;
  assign stall_cnt = r_stall_cnt;
  assign miss_cnt  = r_miss_cnt;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - vector table and scoreboard bench for hazard_stall_ctrl
module tb_hazard_stall_ctrl;

  typedef struct {
    logic       rst;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       memread;
    logic       br;
    logic       req;
    logic       stall;
    logic       ack;
    logic [4:0] exp;
  } vec_t;

  // {PC_write, IFID_write, IFID_flush, IDEX_bubble, pipe_freeze}
  localparam logic [4:0] C_RUN = 5'b11000;
  localparam logic [4:0] C_LU  = 5'b00010;
  localparam logic [4:0] C_BR  = 5'b11100;
  localparam logic [4:0] C_FRZ = 5'b00001;
  localparam logic [4:0] C_RST = 5'b00110;

  logic clk;
  logic rst;
  logic [4:0] rs1, rs2, rd;
  logic memread, br, req, dstall, ack;

  logic pc_a, ifw_a, fl_a, bub_a, frz_a, to_a;
  logic [15:0] stall_a, miss_a;
  logic pc_b, ifw_b, fl_b, bub_b, frz_b, to_b;
  logic [2:0] stall_b, miss_b;

  int checks = 0;
  int failures = 0;
  logic [4:0] exp_q[$];
  vec_t tbl[9];

  hazard_stall_ctrl u_dut_a (
    .clk_i(clk), .rst_i(rst), .ID_rs_1(rs1), .ID_rs_2(rs2), .EX_MemRead(memread),
    .EX_rd(rd), .ID_branch_taken(br), .MEM_mem_req(req), .dcache_stall_i(dstall),
    .dcache_ack_i(ack), .PC_write(pc_a), .IFID_write(ifw_a), .IFID_flush(fl_a),
    .IDEX_bubble(bub_a), .pipe_freeze(frz_a), .timeout_o(to_a),
    .stall_cnt(stall_a), .miss_cnt(miss_a)
  );

  hazard_stall_ctrl #(.CNT_W(3), .TIMEOUT(4)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .ID_rs_1(rs1), .ID_rs_2(rs2), .EX_MemRead(memread),
    .EX_rd(rd), .ID_branch_taken(br), .MEM_mem_req(req), .dcache_stall_i(dstall),
    .dcache_ack_i(ack), .PC_write(pc_b), .IFID_write(ifw_b), .IFID_flush(fl_b),
    .IDEX_bubble(bub_b), .pipe_freeze(frz_b), .timeout_o(to_b),
    .stall_cnt(stall_b), .miss_cnt(miss_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  function automatic vec_t mk(input logic r, input logic [4:0] s1, input logic [4:0] s2,
                              input logic [4:0] d, input logic mr, input logic b,
                              input logic q, input logic st, input logic a,
                              input logic [4:0] e);
    vec_t v;
    v.rst = r; v.rs1 = s1; v.rs2 = s2; v.rd = d; v.memread = mr; v.br = b;
    v.req = q; v.stall = st; v.ack = a; v.exp = e;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    logic [4:0] e;
    @(negedge clk);
    rst = v.rst; rs1 = v.rs1; rs2 = v.rs2; rd = v.rd; memread = v.memread;
    br = v.br; req = v.req; dstall = v.stall; ack = v.ack;
    exp_q.push_back(v.exp);
    #1;
    e = exp_q.pop_front();
    chk({tag, "_ctl_a"}, {11'd0, pc_a, ifw_a, fl_a, bub_a, frz_a}, {11'd0, e});
    chk({tag, "_ctl_b"}, {11'd0, pc_b, ifw_b, fl_b, bub_b, frz_b}, {11'd0, e});
  endtask

  task automatic post_edge;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_stall_a"}, stall_a, 16'd0);
    chk({tag, "_miss_a"}, miss_a, 16'd0);
    chk({tag, "_stall_b"}, {13'd0, stall_b}, 16'd0);
    chk({tag, "_miss_b"}, {13'd0, miss_b}, 16'd0);
    chk({tag, "_to_a"}, {15'd0, to_a}, 16'd0);
    chk({tag, "_to_b"}, {15'd0, to_b}, 16'd0);
  endtask

  initial begin
    rst = 1'b1; rs1 = '0; rs2 = '0; rd = '0; memread = 1'b0; br = 1'b0;
    req = 1'b0; dstall = 1'b0; ack = 1'b0;

    tbl[0] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, C_RST);
    tbl[1] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN);
    tbl[2] = mk(0, 0, 5, 5, 1, 0, 0, 0, 0, C_LU);
    tbl[3] = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, C_RUN);
    tbl[4] = mk(0, 1, 2, 7, 0, 1, 0, 0, 0, C_BR);
    tbl[5] = mk(0, 3, 4, 3, 1, 1, 0, 0, 0, C_LU);
    tbl[6] = mk(0, 5, 0, 5, 0, 0, 0, 0, 0, C_RUN);
    tbl[7] = mk(0, 31, 1, 31, 1, 0, 0, 0, 0, C_LU);
    tbl[8] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, C_RUN);

    for (int i = 0; i < 9; i++) begin
      apply(tbl[i], $sformatf("tbl%0d", i));
      if (i == 0) begin
        post_edge();
        chk_zero("reset");
      end
    end
    post_edge();
    chk("tbl_stall_a", stall_a, 16'd3);
    chk("tbl_stall_b", {13'd0, stall_b}, 16'd3);
    chk("tbl_miss_a", miss_a, 16'd0);

    // Cache miss: freeze cycles 0..6, ack at cycle 7, load-use masked at cycle 3.
    apply(tbl[0], "miss_rst");
    apply(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, C_FRZ), "miss_c0");
    for (int c = 1; c < 7; c++) begin
      if (c == 3) apply(mk(0, 0, 5, 5, 1, 0, 1, 1, 0, C_FRZ), "miss_lu");
      else        apply(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, C_FRZ), $sformatf("miss_c%0d", c));
    end
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, C_RUN), "miss_ack");
    post_edge();
    chk("miss_miss_a", miss_a, 16'd1);
    chk("miss_stall_a", stall_a, 16'd7);
    chk("miss_miss_b", {13'd0, miss_b}, 16'd1);
    chk("miss_stall_b", {13'd0, stall_b}, 16'd7);
    chk("miss_to_a", {15'd0, to_a}, 16'd0);
    chk("miss_to_b", {15'd0, to_b}, 16'd1);
    apply(tbl[1], "miss_after");

    // Timeout (TIMEOUT=4 on instance b), sticky across ack, cleared by mid-wait reset.
    apply(tbl[0], "to_rst");
    apply(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, C_FRZ), "to_start");
    for (int c = 1; c < 4; c++)
      apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ), $sformatf("to_w%0d", c));
    post_edge();
    chk("to_before_b", {15'd0, to_b}, 16'd0);
    apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ), "to_w4");
    post_edge();
    chk("to_rise_b", {15'd0, to_b}, 16'd1);
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, C_RUN), "to_ack");
    post_edge();
    chk("to_sticky_b", {15'd0, to_b}, 16'd1);
    chk("to_sticky_a", {15'd0, to_a}, 16'd0);
    apply(tbl[1], "to_idle");
    apply(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, C_FRZ), "to_miss2");
    apply(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, C_FRZ), "to_miss2_w");
    apply(mk(1, 0, 0, 0, 0, 0, 1, 1, 0, C_RST), "to_midrst");
    post_edge();
    chk_zero("midrst");
    apply(tbl[1], "to_run");

    // Saturation: 10 load-use cycles, 3-bit counter holds at 7.
    apply(tbl[0], "sat_rst");
    for (int c = 0; c < 10; c++)
      apply(mk(0, 9, 0, 9, 1, 0, 0, 0, 0, C_LU), $sformatf("sat_lu%0d", c));
    post_edge();
    chk("sat_stall_b", {13'd0, stall_b}, 16'd7);
    chk("sat_stall_a", stall_a, 16'd10);
    chk("sat_miss_b", {13'd0, miss_b}, 16'd0);
    apply(tbl[8], "sat_spur_ack");
    apply(tbl[1], "sat_idle");
    post_edge();
    chk("sat_spur_miss_a", miss_a, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Pipeline sequencing controller for the 5-stage CPU. It detects load-use hazards that operand forwarding cannot cover, flushes IF/ID on branches taken in ID, and freezes the whole pipeline while the data cache services a miss. It also keeps saturating performance counters and flags a miss-wait timeout. It sits beside the forwarding logic and drives the PC, IF/ID and ID/EX register enables.

Parameters:
CNT_W, 16, width of the stall_cnt and miss_cnt performance counters
TIMEOUT, 64, number of MEM_WAIT cycles before timeout_o is set; 0 disables the timeout

Ports:
clk_i  input  1  clock; all state updates on the rising edge
rst_i  input  1  synchronous, active-high reset
ID_rs_1  input  5  rs1 of the instruction in ID
ID_rs_2  input  5  rs2 of the instruction in ID
EX_MemRead  input  1  instruction in EX is a load
EX_rd  input  5  destination register of the instruction in EX
ID_branch_taken  input  1  branch resolved taken in ID this cycle
MEM_mem_req  input  1  instruction in MEM accesses the data cache
dcache_stall_i  input  1  data cache cannot complete this cycle (level)
dcache_ack_i  input  1  single-cycle pulse: miss serviced, data valid
PC_write  output  1  PC register load enable
IFID_write  output  1  IF/ID register load enable
IFID_flush  output  1  load a NOP into IF/ID
IDEX_bubble  output  1  load a NOP into ID/EX (control bits zeroed)
pipe_freeze  output  1  hold every pipeline register, including EX/MEM and MEM/WB
timeout_o  output  1  sticky: a miss wait exceeded TIMEOUT cycles
stall_cnt  output  CNT_W  cycles with freeze or load-use bubble, saturating
miss_cnt  output  CNT_W  number of MEM_WAIT entries, saturating

Behaviour:
- FSM states: RUN, MEM_WAIT. Registered state plus wait_cnt, stall_cnt, miss_cnt and timeout_o. Control outputs are combinational, with zero-cycle latency from the inputs and state.
- Reset (rst_i=1 at a clock edge): state goes to RUN; wait_cnt, stall_cnt, miss_cnt and timeout_o go to 0. While rst_i=1 the outputs are forced to PC_write=0, IFID_write=0, IFID_flush=1, IDEX_bubble=1, pipe_freeze=0. Reset during MEM_WAIT aborts the wait immediately and returns to RUN.
- miss_start = (state==RUN) & MEM_mem_req & dcache_stall_i.
- freeze = miss_start | ((state==MEM_WAIT) & !dcache_ack_i).
- RUN to MEM_WAIT on miss_start; miss_cnt increments (saturating at all-ones); wait_cnt is cleared.
- MEM_WAIT to RUN on dcache_ack_i. In the ack cycle freeze=0, so the pipeline advances and captures the data. dcache_ack_i is ignored in RUN.
- In MEM_WAIT, wait_cnt increments each cycle without ack. When wait_cnt reaches TIMEOUT-1 and TIMEOUT!=0, timeout_o is set to 1 and stays set until reset. The FSM keeps waiting.
- load_use = EX_MemRead & (EX_rd!=0) & ((EX_rd==ID_rs_1) | (EX_rd==ID_rs_2)) & !freeze.
- Output priority is freeze > load_use > branch:
  - freeze: pipe_freeze=1, PC_write=0, IFID_write=0, IDEX_bubble=0, IFID_flush=0.
  - load_use: PC_write=0, IFID_write=0, IDEX_bubble=1, IFID_flush=0.
  - Branch taken with no hazard: PC_write=1, IFID_write=1, IFID_flush=1.
  - Otherwise: PC_write=1, IFID_write=1, all others 0.
- Branch and load-use in the same cycle: the flush is suppressed, because the branch re-resolves next cycle with the forwarded operand.
- stall_cnt increments (saturating) in every non-reset cycle where freeze or load_use is 1.
- Register x0 never causes a load-use stall.

Test Plan:
- Reset then idle: all inputs 0 -> PC_write=1, IFID_write=1, other controls 0, counters 0, state RUN.
- Load-use: EX_MemRead=1, EX_rd=5, ID_rs_2=5 for one cycle -> PC_write=0, IFID_write=0, IDEX_bubble=1 that cycle; stall_cnt=1. Repeat with EX_rd=0 -> no stall.
- Branch flush: ID_branch_taken=1 with no hazard -> IFID_flush=1, PC_write=1. Branch plus load-use (EX_rd=3=ID_rs_1) -> IFID_flush=0, IDEX_bubble=1.
- Cache miss: MEM_mem_req=1, dcache_stall_i=1 at cycle 0, ack pulse at cycle 7 -> pipe_freeze=1 for cycles 0 through 6 and 0 at cycle 7; miss_cnt=1, stall_cnt=7. A concurrent load-use during the freeze gives IDEX_bubble=0.
- Timeout with TIMEOUT=4: miss with no ack -> timeout_o rises after 4 MEM_WAIT cycles and stays 1 after a later ack. Asserting rst_i mid-wait -> RUN, timeout_o=0, counters 0 on the next cycle.
- Saturation with CNT_W=3: 10 consecutive load-use cycles -> stall_cnt holds at 7. A spurious dcache_ack_i in RUN -> no state change.
